// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// The optional ARB_ROUND_ROBIN_EN build adds a last-winner register in the arbiter.
package sram_arb_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WEN_W   = 4;
    localparam int unsigned MEM_LAT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } owner_state_e;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    typedef struct packed {
        logic [WEN_W-1:0]  wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational grant decision between the fetch and load/store ports.
// ARB_ROUND_ROBIN_EN: conflicts go to the port that lost the previous conflict; otherwise data wins.
module sram_arb_grant
    import sram_arb_pkg::*;
(
    input  logic inst_req_i,
    input  logic data_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_win_i,
`endif
    output logic grant_inst_o,
    output logic grant_data_o
);

    logic conflict;

    always_comb begin
        conflict     = inst_req_i & data_req_i;
        grant_inst_o = inst_req_i & ~data_req_i;
        grant_data_o = data_req_i & ~inst_req_i;
        if (conflict) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_data_o = (last_win_i == REQ_INST);
            grant_inst_o = (last_win_i == REQ_DATA);
`else
            grant_data_o = 1'b1;
            grant_inst_o = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single SRAM with one-cycle read latency.
// Define ARB_ROUND_ROBIN_EN for alternating conflict priority; default is data-first.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [WEN_W-1:0]    data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_en,
    output logic [WEN_W-1:0]    mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [CNT_W-1:0]    conflict_cnt
);

    owner_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inst_req_v, data_req_v, both_req;
    logic             grant_inst, grant_data;
    mem_cmd_t         cmd;

    // Requests seen during reset are dropped, never latched.
    assign inst_req_v = inst_req & ~rst;
    assign data_req_v = data_req & ~rst;
    assign both_req   = inst_req_v & data_req_v;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_win_q, last_win_d;
`endif

    sram_arb_grant u_grant (
        .inst_req_i   (inst_req_v),
        .data_req_i   (data_req_v),
`ifdef ARB_ROUND_ROBIN_EN
        .last_win_i   (last_win_q),
`endif
        .grant_inst_o (grant_inst),
        .grant_data_o (grant_data)
    );

    // Reset leaves last winner = inst so the first conflict after reset goes to data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_win_q <= REQ_INST;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_win_q <= last_win_d;
`endif
        end
    end

    always_comb begin
        state_d = IDLE;
        cnt_d   = cnt_q;
        if (grant_inst) begin
            state_d = RESP_I;
        end else if (grant_data) begin
            state_d = RESP_D;
        end
        if (both_req && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_win_d = last_win_q;
        if (both_req) begin
            last_win_d = grant_data ? REQ_DATA : REQ_INST;
        end
`endif
    end

    // Memory command mux; idle cycles drive all zeros.
    always_comb begin
        cmd = '0;
        if (grant_data) begin
            cmd.wen   = data_wen;
            cmd.addr  = data_addr;
            cmd.wdata = data_wdata;
        end else if (grant_inst) begin
            cmd.addr  = inst_addr;
        end
    end

    assign mem_en       = grant_inst | grant_data;
    assign mem_wen      = cmd.wen;
    assign mem_addr     = cmd.addr;
    assign mem_wdata    = cmd.wdata;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // Responses in flight when reset asserts are squashed immediately.
    assign inst_data_ok = (state_q == RESP_I) & ~rst;
    assign data_data_ok = (state_q == RESP_D) & ~rst;
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    assign conflict_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed scenarios then randomized traffic.
// A second instance with a 4-bit counter shares all inputs to exercise saturation.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_en;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wen;
    logic [31:0] conflict_cnt;

    logic        s_inst_addr_ok, s_inst_data_ok, s_data_addr_ok, s_data_data_ok, s_mem_en;
    logic [31:0] s_inst_rdata, s_data_rdata, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_wen;
    logic [3:0]  s_conflict_cnt;

    always #5 clk = ~clk;

    sram_port_arbiter #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    sram_port_arbiter #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(s_inst_addr_ok),
        .inst_data_ok(s_inst_data_ok), .inst_rdata(s_inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(s_data_addr_ok), .data_data_ok(s_data_data_ok), .data_rdata(s_data_rdata),
        .mem_en(s_mem_en), .mem_wen(s_mem_wen), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(s_conflict_cnt)
    );

    typedef struct {
        int          cyc;
        bit          is_data;
        logic [31:0] rdata;
    } resp_t;

    resp_t       sb_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          cnt_model = 0;
    bit          rr_data_next = 1'b1;
    bit          have_next = 1'b0;
    logic [31:0] next_rdata = '0;
    bit          use_pin = 1'b0;
    logic [31:0] pin_rdata = '0;

    function automatic void check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endfunction

    // One clock: drive inputs after negedge, predict grant/command from the port rules, queue the response.
    task automatic tick(input logic r, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] dwd, output logic acc_i, output logic acc_d);
        logic        gi, gd;
        logic [3:0]  e_wen;
        logic [31:0] e_addr, e_wdata, rd, e_cnt, e_scnt;
        @(negedge clk);
        cyc++;
        rst = r; inst_req = ir; inst_addr = ia;
        data_req = dr; data_wen = dw; data_addr = da; data_wdata = dwd;
        mem_rdata = have_next ? next_rdata : $urandom();
        have_next = 1'b0;
        #1;
        gi = 1'b0; gd = 1'b0;
        if (!r) begin
            if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
                gd = rr_data_next;
`else
                gd = 1'b1;
`endif
                gi = !gd;
            end else begin
                gi = ir; gd = dr;
            end
        end
        e_wen   = gd ? dw : 4'h0;
        e_addr  = gd ? da : (gi ? ia : 32'h0);
        e_wdata = gd ? dwd : 32'h0;
        e_cnt   = r ? 32'd0 : 32'(cnt_model);
        e_scnt  = (e_cnt > 32'd15) ? 32'd15 : e_cnt;
        if (r) sb_q.delete();
        check("addr_ok_mem_en", 96'({inst_addr_ok, data_addr_ok, mem_en}), 96'({gi, gd, gi | gd}));
        check("mem_cmd", 96'({mem_wen, mem_addr, mem_wdata}), 96'({e_wen, e_addr, e_wdata}));
        check("conflict_cnt", 96'(conflict_cnt), 96'(e_cnt));
        check("s_addr_ok_mem_en", 96'({s_inst_addr_ok, s_data_addr_ok, s_mem_en}), 96'({gi, gd, gi | gd}));
        check("s_mem_cmd", 96'({s_mem_wen, s_mem_addr, s_mem_wdata}), 96'({e_wen, e_addr, e_wdata}));
        check("s_conflict_cnt_sat", 96'(s_conflict_cnt), 96'(e_scnt));
        if (gi || gd) begin
            rd = use_pin ? pin_rdata : $urandom();
            sb_q.push_back('{cyc: cyc + 1, is_data: gd, rdata: rd});
            have_next  = 1'b1;
            next_rdata = rd;
        end
        if (r) begin
            cnt_model    = 0;
            rr_data_next = 1'b1;
        end else if (ir && dr) begin
            cnt_model++;
            rr_data_next = !gd;
        end
        acc_i = gi; acc_d = gd;
    endtask

    // Monitor: every cycle, match data_ok/rdata of both instances against the queued response.
    initial begin
        resp_t       e;
        logic [65:0] exp_resp;
        forever begin
            @(negedge clk);
            #2;
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                n_total++;
                $display("FAIL resp_lost cycle %0d: response due cycle %0d never checked", cyc, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e = sb_q.pop_front();
                exp_resp = {!e.is_data, e.is_data, e.is_data ? 32'h0 : e.rdata, e.is_data ? e.rdata : 32'h0};
            end else begin
                exp_resp = '0;
            end
            check("resp", 96'({inst_data_ok, data_data_ok, inst_rdata, data_rdata}), 96'(exp_resp));
            check("s_resp", 96'({s_inst_data_ok, s_data_data_ok, s_inst_rdata, s_data_rdata}), 96'(exp_resp));
        end
    end

    initial begin
        logic        ai, ad, r;
        bit          pi_v, pd_v;
        logic [31:0] pi_a, pd_a, pd_wd;
        logic [3:0]  pd_w;
        pi_v = 1'b0; pd_v = 1'b0;
        pi_a = '0; pd_a = '0; pd_wd = '0; pd_w = '0;

        repeat (3) tick(1'b1, 1'b0, '0, 1'b0, '0, '0, '0, ai, ad);

        // Fetch only with a known instruction word.
        use_pin = 1'b1; pin_rdata = 32'h2401_0001;
        tick(1'b0, 1'b1, 32'hBFC0_0000, 1'b0, '0, '0, '0, ai, ad);
        use_pin = 1'b0;
        tick(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, ai, ad);

        // Full-word store.
        tick(1'b0, 1'b0, '0, 1'b1, 4'hF, 32'h8000_1000, 32'hDEAD_BEEF, ai, ad);
        tick(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, ai, ad);

        // Fresh reset, then both requests held (3 cycles, then 4 more back to back).
        tick(1'b1, 1'b0, '0, 1'b0, '0, '0, '0, ai, ad);
        repeat (3) tick(1'b0, 1'b1, 32'hBFC0_0010, 1'b1, 4'h0, 32'h8000_2000, '0, ai, ad);
        tick(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, ai, ad);
        tick(1'b1, 1'b0, '0, 1'b0, '0, '0, '0, ai, ad);
        repeat (4) tick(1'b0, 1'b1, 32'hBFC0_0020, 1'b1, 4'h3, 32'h8000_3000, 32'h1234_5678, ai, ad);
        tick(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, ai, ad);

        // Load granted, reset the next cycle with requests present: response discarded.
        tick(1'b0, 1'b0, '0, 1'b1, 4'h0, 32'h8000_4000, '0, ai, ad);
        tick(1'b1, 1'b1, 32'hBFC0_0030, 1'b1, 4'h0, 32'h8000_4004, '0, ai, ad);
        repeat (2) tick(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, ai, ad);

        // Long conflict to saturate the 4-bit counter.
        tick(1'b1, 1'b0, '0, 1'b0, '0, '0, '0, ai, ad);
        repeat (20) tick(1'b0, 1'b1, 32'hBFC0_0040, 1'b1, 4'h1, 32'h8000_5000, 32'hA5A5_A5A5, ai, ad);
        repeat (2) tick(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, ai, ad);

        // Random traffic; a losing request is held stable until accepted.
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(99) < 3);
            if (!pi_v && $urandom_range(99) < 60) begin
                pi_v = 1'b1;
                pi_a = $urandom() & 32'hFFFF_FFFC;
            end
            if (!pd_v && $urandom_range(99) < 60) begin
                pd_v  = 1'b1;
                pd_a  = $urandom() & 32'hFFFF_FFFC;
                pd_w  = ($urandom_range(1) == 1) ? 4'($urandom()) : 4'h0;
                pd_wd = $urandom();
            end
            tick(r, pi_v, pi_a, pd_v, pd_w, pd_a, pd_wd, ai, ad);
            if (ai) pi_v = 1'b0;
            if (ad) pd_v = 1'b0;
        end

        repeat (2) tick(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, ai, ad);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter CNT_W, default 32, width of the conflict counter.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 inst_req  in  1  fetch request; inst_addr  in  32  fetch address.
REQ-005 inst_addr_ok  out  1  fetch accepted this cycle; inst_data_ok  out  1  fetch data valid; inst_rdata  out  32  fetch data.
REQ-006 data_req  in  1  load/store request; data_wen  in  4  byte enables, 0 = load; data_addr  in  32; data_wdata  in  32.
REQ-007 data_addr_ok  out  1  load/store accepted; data_data_ok  out  1  load data valid or store done; data_rdata  out  32.
REQ-008 mem_en  out  1; mem_wen  out  4; mem_addr  out  32; mem_wdata  out  32; mem_rdata  in  32.
REQ-009 mem_rdata is valid exactly one cycle after the mem_en cycle.
REQ-010 conflict_cnt  out  CNT_W  cycles in which both requests were pending.

Function
REQ-011 At most one requester is granted per cycle.
REQ-012 A grant is legal in every cycle, including the cycle in which the previous response returns; back-to-back throughput is one access per cycle.
REQ-013 Grant cycle: drive mem_en=1, mem_addr/mem_wen/mem_wdata from the winner, and assert the winner's addr_ok combinationally.
REQ-014 For an inst grant, mem_wen = 4'b0000 and mem_wdata = 0.
REQ-015 With no grant: mem_en=0, mem_wen=0; addr/wdata are don't-care but held at 0.
REQ-016 Owner FSM states: IDLE (no response outstanding), RESP_I, RESP_D; the next state is decided by the grant in the current cycle, else IDLE.
REQ-017 In RESP_I: inst_data_ok=1 and inst_rdata=mem_rdata; in RESP_D: data_data_ok=1 and data_rdata=mem_rdata, for stores as well.
REQ-018 The rdata output of a requester not in its RESP state is 0.
REQ-019 Only one request is pending: it wins.
REQ-020 Both pending: the winner follows REQ-030/031; the loser sees addr_ok=0 and must hold its request stable.
REQ-021 conflict_cnt increments when inst_req and data_req are both 1, and saturates at all-ones.
REQ-022 A request is accepted only in a cycle in which its addr_ok=1; an accepted request produces exactly one data_ok, which follows one cycle later.

Reset
REQ-023 While rst=1: FSM=IDLE, all addr_ok/data_ok=0, mem_en=0, mem_wen=0, rdata outputs=0, conflict_cnt=0, RR pointer=data.
REQ-024 A response outstanding when rst asserts is discarded; no data_ok is issued for it after reset.
REQ-025 Requests presented during rst are ignored, not latched.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN selects the conflict policy.
REQ-027 Defined: a 1-bit last-winner register exists; on conflict the requester that did not win the last conflict is granted.
REQ-028 Undefined: the last-winner register is absent.
REQ-029 Non-conflict grants never update last-winner.
REQ-030 With ARB_ROUND_ROBIN_EN, conflict priority alternates per REQ-027.
REQ-031 Without ARB_ROUND_ROBIN_EN, data always wins conflicts (fixed priority).

Structure
REQ-032 Shared package sram_arb_pkg holds the FSM state enum (IDLE/RESP_I/RESP_D), requester ID constants (REQ_INST=0, REQ_DATA=1) and MEM_LAT=1.
REQ-033 One sub-module is natural: sram_arb_grant, purely combinational, from inst_req/data_req/last-winner to grant_inst/grant_data; the FSM, counter and muxes stay in the top.

Verification
REQ-034 Inst only: inst_req=1, addr=0xBFC00000, mem_rdata=0x24010001 -> inst_addr_ok same cycle, mem_en=1, mem_wen=0; next cycle inst_data_ok=1, inst_rdata=0x24010001.
REQ-035 Store: data_req=1, wen=4'b1111, addr=0x80001000, wdata=0xDEADBEEF -> mem_wen=4'hF, mem_wdata=0xDEADBEEF; data_data_ok=1 next cycle.
REQ-036 Conflict, ARB_ROUND_ROBIN_EN undefined, both requests held 3 cycles -> data granted 3 times, inst_addr_ok=0 throughout, conflict_cnt=3.
REQ-037 Conflict, ARB_ROUND_ROBIN_EN defined, both held 4 cycles -> grants D,I,D,I; each data_ok one cycle after its grant.
REQ-038 Reset mid-op: data load granted, rst=1 in the next cycle -> data_data_ok=0 in that cycle and after it; conflict_cnt=0.
REQ-039 Saturation: CNT_W=4, conflict held 20 cycles -> conflict_cnt stops at 15.
